// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative multiply/divide behind valid/ready handshakes.
// Single-cycle ops finish in one cycle; MDU ops take N+1 cycles.
module alu_mdu #(
  parameter int N = 32,
  localparam int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         zero,
  output logic         overflow,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [N-1:0] NV = N'(N);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   hi_reg, lo_reg, mcand_reg;
  logic           is_div_reg, neg_lo_reg, neg_hi_reg;
  logic [N-1:0]   result_reg, result_hi_reg;
  logic           zero_reg, overflow_reg, dbz_reg;

  logic           is_mdu, is_div_op, b_is_zero, start_iter, a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic [N-1:0]   shamt, sum, diff, alu_res;
  logic           alu_ovf;
  logic [N:0]     mul_sum, div_rem, div_diff;
  logic [N-1:0]   step_hi, step_lo, fin_lo, fin_hi;
  logic [2*N-1:0] prod, prod_fix;

  assign is_mdu     = op[3] & op[2];
  assign is_div_op  = is_mdu & op[1];
  assign b_is_zero  = (b == '0);
  assign start_iter = is_mdu & ~(is_div_op & b_is_zero);
  assign a_neg      = is_mdu & op[0] & a[N-1];
  assign b_neg      = is_mdu & op[0] & b[N-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;

  assign shamt = b % NV;
  assign sum   = a + b;
  assign diff  = a - b;

  always_comb begin
    alu_res = a & b;
    alu_ovf = 1'b0;
    case (op)
      4'd1:  alu_res = a | b;
      4'd2: begin
        alu_res = sum;
        alu_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      4'd3:  alu_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd4:  alu_res = a & ~b;
      4'd5:  alu_res = a | ~b;
      4'd6: begin
        alu_res = diff;
        alu_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      4'd7:  alu_res = {{(N-1){1'b0}}, (a < b)};
      4'd8:  alu_res = a << shamt;
      4'd9:  alu_res = a >> shamt;
      4'd10: alu_res = $unsigned($signed(a) >>> shamt);
      default: alu_res = a & b;
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring divide on {hi,lo}.
  assign mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(N+1){1'b0}});
  assign div_rem  = {hi_reg, lo_reg[N-1]};
  assign div_diff = div_rem - {1'b0, mcand_reg};

  always_comb begin
    step_hi = mul_sum[N:1];
    step_lo = {mul_sum[0], lo_reg[N-1:1]};
    if (is_div_reg) begin
      if (!div_diff[N]) begin
        step_hi = div_diff[N-1:0];
        step_lo = {lo_reg[N-2:0], 1'b1};
      end else begin
        step_hi = div_rem[N-1:0];
        step_lo = {lo_reg[N-2:0], 1'b0};
      end
    end
  end

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_lo_reg ? -prod : prod;
  assign fin_lo   = is_div_reg ? (neg_lo_reg ? -step_lo : step_lo) : prod_fix[N-1:0];
  assign fin_hi   = is_div_reg ? (neg_hi_reg ? -step_hi : step_hi) : prod_fix[2*N-1:N];

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = start_iter ? BUSY : DONE;
      BUSY:    if (cnt_reg == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = resetn && (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      mcand_reg     <= '0;
      is_div_reg    <= 1'b0;
      neg_lo_reg    <= 1'b0;
      neg_hi_reg    <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          if (!is_mdu) begin
            result_reg    <= alu_res;
            result_hi_reg <= '0;
            zero_reg      <= (alu_res == '0);
            overflow_reg  <= alu_ovf;
            dbz_reg       <= 1'b0;
          end else if (!start_iter) begin
            result_reg    <= '1;
            result_hi_reg <= a;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            dbz_reg       <= 1'b1;
          end else begin
            hi_reg     <= '0;
            lo_reg     <= a_mag;
            mcand_reg  <= b_mag;
            cnt_reg    <= CW'(N);
            is_div_reg <= is_div_op;
            neg_lo_reg <= a_neg ^ b_neg;
            neg_hi_reg <= is_div_op ? a_neg : (a_neg ^ b_neg);
          end
        end
        BUSY: begin
          hi_reg  <= step_hi;
          lo_reg  <= step_lo;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            result_reg    <= fin_lo;
            result_hi_reg <= fin_hi;
            zero_reg      <= (fin_lo == '0);
            overflow_reg  <= 1'b0;
            dbz_reg       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result      = result_reg;
  assign result_hi   = result_hi_reg;
  assign zero        = zero_reg;
  assign overflow    = overflow_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (N=32): directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_alu_mdu;

  logic        clk, resetn, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b, result, result_hi;
  logic        zero, overflow, div_by_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r, h;
    logic [2:0]  f;
    int          lat;
    int          hold;
  } vec_t;

  alu_mdu #(.N(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected outputs and latency from the arithmetic rules.
  function automatic void model(input logic [3:0] mop, input logic [31:0] ma, mb,
                                output logic [31:0] r, h, output logic [2:0] f,
                                output int lat);
    longint sa = longint'($signed(ma));
    longint sb = longint'($signed(mb));
    longint s, q, rm;
    logic [63:0] up;
    int sh = int'(mb % 32);
    logic o = 1'b0, d = 1'b0;
    r = 32'h0; h = 32'h0; lat = 1;
    case (mop)
      4'd1:  r = ma | mb;
      4'd2:  begin s = sa + sb; r = 32'(s); o = (longint'($signed(r)) != s); end
      4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  r = ma & ~mb;
      4'd5:  r = ma | ~mb;
      4'd6:  begin s = sa - sb; r = 32'(s); o = (longint'($signed(r)) != s); end
      4'd7:  r = (ma < mb) ? 32'd1 : 32'd0;
      4'd8:  r = ma << sh;
      4'd9:  r = ma >> sh;
      4'd10: r = 32'(sa >>> sh);
      4'd12: begin up = {32'h0, ma} * {32'h0, mb}; r = up[31:0]; h = up[63:32]; lat = 33; end
      4'd13: begin s = sa * sb; r = 32'(s); h = 32'(s >>> 32); lat = 33; end
      4'd14, 4'd15: begin
        if (mb == 32'h0) begin
          r = 32'hFFFFFFFF; h = ma; d = 1'b1;
        end else if (mop == 4'd14) begin
          r = ma / mb; h = ma % mb; lat = 33;
        end else begin
          q = sa / sb; rm = sa % sb; r = 32'(q); h = 32'(rm); lat = 33;
        end
      end
      default: r = ma & mb;
    endcase
    f = {(r == 32'h0), o, d};
  endfunction

  // Drive one operation, wait for the result, hold it, consume it.
  task automatic run_op(input logic [3:0] o_op, input logic [31:0] oa, ob, input int hold,
                        output int lat, output logic [31:0] r, h, output logic [2:0] f,
                        output int ready_bad, output int stable_bad, output logic after_ok);
    int w = 0;
    @(negedge clk);
    op = o_op; a = oa; b = ob; in_valid = 1'b1; out_ready = 1'b0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    // Keep presenting garbage while busy; it must not be sampled.
    op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0; ready_bad = 0;
    do begin
      @(negedge clk); lat++;
      if (in_ready) ready_bad++;
    end while (!out_valid && lat < 100);
    r = result; h = result_hi; f = {zero, overflow, div_by_zero};
    stable_bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (result !== r || result_hi !== h || !out_valid) stable_bad++;
      if (in_ready) ready_bad++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    after_ok = !out_valid && in_ready;
    $display("op=%0d a=%h b=%h -> r=%h h=%h f=%b lat=%0d", o_op, oa, ob, r, h, f, lat);
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = 32'h0; b = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, zero, overflow, div_by_zero} !== 5'b0 || result !== 32'h0 || result_hi !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b r=%h h=%h f=%b%b%b, want all 0",
               in_ready, out_valid, result, result_hi, zero, overflow, div_by_zero);
    end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_sub();
    vec_t v[3];
    int lat, rb, sb; logic [31:0] r, h; logic [2:0] f; logic ok;
    v[0] = '{4'd2, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 3'b010, 1, 0};
    v[1] = '{4'd6, 32'd5, 32'd5, 32'h0, 32'h0, 3'b100, 1, 0};
    v[2] = '{4'd6, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 3'b010, 1, 0};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].hold, lat, r, h, f, rb, sb, ok);
      total++;
      if (lat != v[i].lat || r !== v[i].r || h !== v[i].h || f !== v[i].f || rb != 0 || sb != 0 || ok !== 1'b1) begin
        bad++;
        $display("FAIL add_sub[%0d]: got lat=%0d r=%h h=%h f=%b rb=%0d ok=%b, want lat=%0d r=%h h=%h f=%b",
                 i, lat, r, h, f, rb, ok, v[i].lat, v[i].r, v[i].h, v[i].f);
      end
    end
  endtask

  task automatic test_cmp_shift();
    vec_t v[6];
    int lat, rb, sb; logic [31:0] r, h; logic [2:0] f; logic ok;
    v[0] = '{4'd3,  32'hFFFFFFFF, 32'h1,  32'h1,        32'h0, 3'b000, 1, 0};
    v[1] = '{4'd7,  32'hFFFFFFFF, 32'h1,  32'h0,        32'h0, 3'b100, 1, 0};
    v[2] = '{4'd10, 32'h80000000, 32'h24, 32'hF8000000, 32'h0, 3'b000, 1, 0};
    v[3] = '{4'd8,  32'h1,        32'd33, 32'h2,        32'h0, 3'b000, 1, 0};
    v[4] = '{4'd9,  32'h80000000, 32'd31, 32'h1,        32'h0, 3'b000, 1, 0};
    v[5] = '{4'd11, 32'hF0,       32'h3C, 32'h30,       32'h0, 3'b000, 1, 0};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].hold, lat, r, h, f, rb, sb, ok);
      total++;
      if (lat != v[i].lat || r !== v[i].r || h !== v[i].h || f !== v[i].f || rb != 0 || ok !== 1'b1) begin
        bad++;
        $display("FAIL cmp_shift[%0d]: got lat=%0d r=%h h=%h f=%b ok=%b, want lat=%0d r=%h h=%h f=%b",
                 i, lat, r, h, f, ok, v[i].lat, v[i].r, v[i].h, v[i].f);
      end
    end
  endtask

  task automatic test_mult();
    vec_t v[3];
    int lat, rb, sb; logic [31:0] r, h; logic [2:0] f; logic ok;
    v[0] = '{4'd13, 32'hFFFFFFFD, 32'd7,     32'hFFFFFFEB, 32'hFFFFFFFF, 3'b000, 33, 0};
    v[1] = '{4'd12, 32'h10000,    32'h10000, 32'h0,        32'h1,        3'b100, 33, 0};
    v[2] = '{4'd13, 32'h80000000, 32'h80000000, 32'h0,     32'h40000000, 3'b100, 33, 1};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].hold, lat, r, h, f, rb, sb, ok);
      total++;
      if (lat != v[i].lat || r !== v[i].r || h !== v[i].h || f !== v[i].f || rb != 0 || sb != 0 || ok !== 1'b1) begin
        bad++;
        $display("FAIL mult[%0d]: got lat=%0d r=%h h=%h f=%b rb=%0d ok=%b, want lat=%0d r=%h h=%h f=%b rb=0",
                 i, lat, r, h, f, rb, ok, v[i].lat, v[i].r, v[i].h, v[i].f);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[5];
    int lat, rb, sb; logic [31:0] r, h; logic [2:0] f; logic ok;
    v[0] = '{4'd15, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 3'b000, 33, 0};
    v[1] = '{4'd14, 32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        3'b001, 1,  0};
    v[2] = '{4'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        3'b000, 33, 0};
    v[3] = '{4'd15, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        3'b000, 33, 0};
    v[4] = '{4'd15, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        3'b001, 1,  0};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].hold, lat, r, h, f, rb, sb, ok);
      total++;
      if (lat != v[i].lat || r !== v[i].r || h !== v[i].h || f !== v[i].f || rb != 0 || ok !== 1'b1) begin
        bad++;
        $display("FAIL div[%0d]: got lat=%0d r=%h h=%h f=%b ok=%b, want lat=%0d r=%h h=%h f=%b",
                 i, lat, r, h, f, ok, v[i].lat, v[i].r, v[i].h, v[i].f);
      end
    end
  endtask

  task automatic test_hold();
    int lat, rb, sb; logic [31:0] r, h; logic [2:0] f; logic ok;
    run_op(4'd14, 32'd100, 32'd7, 10, lat, r, h, f, rb, sb, ok);
    total++;
    if (r !== 32'd14 || h !== 32'd2 || f !== 3'b000 || lat != 33 || rb != 0 || sb != 0 || ok !== 1'b1) begin
      bad++;
      $display("FAIL hold: got r=%h h=%h f=%b lat=%0d rb=%0d sb=%0d ok=%b, want r=0000000e h=00000002 f=000 lat=33 rb=0 sb=0 ok=1",
               r, h, f, lat, rb, sb, ok);
    end
    // Already in the first idle cycle after consumption: present the next op now.
    op = 4'd2; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || result !== 32'd7) begin
      bad++;
      $display("FAIL hold_next: got vld=%b r=%h, want vld=1 r=00000007", out_valid, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int lat, rb, sb; logic [31:0] r, h; logic [2:0] f; logic ok;
    @(negedge clk);
    op = 4'd12; a = 32'h12345678; b = 32'h9ABCDEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, zero, overflow, div_by_zero} !== 5'b0 || result !== 32'h0 || result_hi !== 32'h0) begin
      bad++;
      $display("FAIL reset_busy: got rdy=%b vld=%b r=%h h=%h f=%b%b%b, want all 0",
               in_ready, out_valid, result, result_hi, zero, overflow, div_by_zero);
    end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    end
    run_op(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, r, h, f, rb, sb, ok);
    total++;
    if (r !== 32'h00000001 || h !== 32'hFFFFFFFE || f !== 3'b000 || lat != 33 || rb != 0 || ok !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy_fresh: got r=%h h=%h f=%b lat=%0d ok=%b, want r=00000001 h=fffffffe f=000 lat=33",
               r, h, f, lat, ok);
    end
  endtask

  task automatic test_random();
    int lat, rb, sb, elat, hold, sel;
    logic [31:0] r, h, er, eh, ra, rbv;
    logic [2:0] f, ef;
    logic ok;
    logic [3:0] rop;
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom; rbv = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rbv = 32'h0;
      else if (sel == 1) begin ra = 32'h80000000; rbv = 32'hFFFFFFFF; end
      else if (sel == 2) rbv = ra;
      else if (sel == 3) rbv = 32'($urandom_range(1, 40));
      hold = $urandom_range(0, 2);
      model(rop, ra, rbv, er, eh, ef, elat);
      run_op(rop, ra, rbv, hold, lat, r, h, f, rb, sb, ok);
      total++;
      if (lat != elat || r !== er || h !== eh || f !== ef || rb != 0 || sb != 0 || ok !== 1'b1) begin
        bad++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d r=%h h=%h f=%b rb=%0d sb=%0d ok=%b, want lat=%0d r=%h h=%h f=%b",
                 i, rop, ra, rbv, lat, r, h, f, rb, sb, ok, elat, er, eh, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_cmp_shift();
    test_mult();
    test_div();
    test_hold();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
